m_lsu_a16: RTL and testbench

Load/store front end placed directly upstream of the 64 KiB SPRAM block. It takes one byte-addressed core access at a time (byte, halfword or word, signed or unsigned load), checks alignment, and runs a single Wishbone-style classic cycle toward the RAM. It builds SEL and lane-replicated write data, waits for ACK with a timeout, then returns one response pulse carrying aligned, extended read data or an error flag.

---
 rtl/m_lsu_pkg.sv | 20 ++
 rtl/m_lsu_lanes.sv | 26 ++
 rtl/m_lsu_a16.sv | 115 +++++++++++
 tb/tb_m_lsu_a16.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/m_lsu_pkg.sv
// m_lsu_pkg: shared encodings and helpers for the load/store unit
package m_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RSP} state_t;

   // Timer must hold TIMEOUT-1; TIMEOUT is limited to 1..255
   function automatic int f_tmr_w(input int t);
      return (t < 2) ? 1 : $clog2(t);
   endfunction

   // Reserved size or an address not aligned to the access size
   function automatic logic f_misalign(input logic [1:0] size, input logic [1:0] adr);
      return (size == 2'd3) || (size == SZ_H && adr[0]) || (size == SZ_W && adr != 2'b00);
   endfunction

endpackage

// File: rtl/m_lsu_lanes.sv
// m_lsu_lanes: byte-lane selects, store replication and load extraction
module m_lsu_lanes
   import m_lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  adr,
   input  logic        uns,
   input  logic [31:0] wdat,
   input  logic [31:0] dat_i,
   output logic [3:0]  sel,
   output logic [31:0] wrep,
   output logic [31:0] rdat
);

   logic [31:0] sh;

   // Lane mapping is purely a function of size and the low address bits
   always_comb begin
      sh   = dat_i >> {adr, 3'b000};
      sel  = (size == SZ_B) ? 4'b0001 << adr : (size == SZ_H) ? (adr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wrep = (size == SZ_B) ? {4{wdat[7:0]}} : (size == SZ_H) ? {2{wdat[15:0]}} : wdat;
      rdat = (size == SZ_B) ? {{24{~uns & sh[7]}}, sh[7:0]} :
             (size == SZ_H) ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
   end

endmodule

// File: rtl/m_lsu_a16.sv
// m_lsu_a16: single-outstanding load/store front end for a classic-cycle RAM
module m_lsu_a16
   import m_lsu_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic        CLK_I,
   input  logic        RST_N_I,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_uns,
   input  logic [15:0] req_adr,
   input  logic [31:0] req_wdat,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdat,
   output logic        STB_O,
   output logic        WE_O,
   output logic [15:0] ADR_O,
   output logic [3:0]  SEL_O,
   output logic [31:0] DAT_O,
   input  logic [31:0] DAT_I,
   input  logic        ACK_I
);

   localparam int TW = f_tmr_w(TIMEOUT);

   state_t      state;
   logic        r_we, r_uns;
   logic [1:0]  r_size;
   logic [TW-1:0] timer;
   logic        idle;
   logic [3:0]  l_sel;
   logic [31:0] l_wrep, l_rdat;

   assign idle      = (state == S_IDLE);
   assign req_ready = idle;

   // In IDLE the lanes see the incoming request; afterwards the registered one
   m_lsu_lanes u_lanes (
      .size  (idle ? req_size : r_size),
      .adr   (idle ? req_adr[1:0] : ADR_O[1:0]),
      .uns   (r_uns),
      .wdat  (req_wdat),
      .dat_i (DAT_I),
      .sel   (l_sel),
      .wrep  (l_wrep),
      .rdat  (l_rdat)
   );

   // Access FSM: accept, run one bus cycle with timeout, emit one response
   always_ff @(posedge CLK_I or negedge RST_N_I)
      if (!RST_N_I) begin
         state     <= S_IDLE;
         r_we      <= 1'b0;
         r_uns     <= 1'b0;
         r_size    <= SZ_B;
         timer     <= '0;
         STB_O     <= 1'b0;
         WE_O      <= 1'b0;
         ADR_O     <= '0;
         SEL_O     <= '0;
         DAT_O     <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdat  <= '0;
      end else
         case (state)
            S_IDLE:
               if (req_valid) begin
                  r_we   <= req_we;
                  r_uns  <= req_uns;
                  r_size <= req_size;
                  ADR_O  <= req_adr;
                  SEL_O  <= l_sel;
                  DAT_O  <= l_wrep;
                  timer  <= '0;
                  if (f_misalign(req_size, req_adr[1:0])) begin
                     state     <= S_RSP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     state <= S_BUS;
                     STB_O <= 1'b1;
                     WE_O  <= req_we;
                  end
               end
            S_BUS:
               if (ACK_I) begin
                  state     <= S_RSP;
                  STB_O     <= 1'b0;
                  WE_O      <= 1'b0;
                  timer     <= '0;
                  rsp_valid <= 1'b1;
                  rsp_rdat  <= r_we ? '0 : l_rdat;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  state     <= S_RSP;
                  STB_O     <= 1'b0;
                  WE_O      <= 1'b0;
                  timer     <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else
                  timer <= timer + 1'b1;
            default: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdat  <= '0;
            end
         endcase

endmodule

// File: tb/tb_m_lsu_a16.sv
// tb_m_lsu_a16: directed and random accesses against a byte-level reference memory
module tb_m_lsu_a16;

   localparam int TO = 4;

   logic        CLK_I = 1'b0;
   logic        RST_N_I = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [15:0] req_adr = '0;
   logic [31:0] req_wdat = '0;
   logic        req_ready, rsp_valid, rsp_err, STB_O, WE_O, ACK_I;
   logic [31:0] rsp_rdat, DAT_O, DAT_I;
   logic [15:0] ADR_O;
   logic [3:0]  SEL_O;

   int checks = 0;
   int errors = 0;

   logic       stall = 1'b0;
   logic       clr = 1'b1;
   logic       ack_rd;
   logic [7:0] mem [65536];
   logic [7:0] ref_mem [65536];
   logic [15:0] wa;

   m_lsu_a16 #(.TIMEOUT(TO)) dut (
      .CLK_I(CLK_I), .RST_N_I(RST_N_I),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_uns(req_uns), .req_adr(req_adr), .req_wdat(req_wdat),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdat(rsp_rdat),
      .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .SEL_O(SEL_O), .DAT_O(DAT_O),
      .DAT_I(DAT_I), .ACK_I(ACK_I)
   );

   always #5 CLK_I = ~CLK_I;

   // Bus-side RAM: writes acknowledge combinationally, reads one cycle later
   assign wa    = {ADR_O[15:2], 2'b00};
   assign ACK_I = !stall && STB_O && (WE_O || ack_rd);
   assign DAT_I = {mem[wa + 16'd3], mem[wa + 16'd2], mem[wa + 16'd1], mem[wa]};

   always @(posedge CLK_I) begin
      ack_rd <= !stall && STB_O && !WE_O && !ack_rd;
      if (clr)
         for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      else if (STB_O && WE_O && ACK_I)
         for (int i = 0; i < 4; i++)
            if (SEL_O[i]) mem[wa + 16'(i)] <= DAT_O[8*i +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic bad(input logic [1:0] size, input logic [15:0] adr);
      int n = 1 << size;
      return size == 2'd3 || (adr % n) != 0;
   endfunction

   function automatic logic [3:0] exp_sel(input logic [1:0] size, input logic [15:0] adr);
      int n = 1 << size;
      return 4'(((1 << n) - 1) << adr[1:0]);
   endfunction

   task automatic ref_store(input logic [1:0] size, input logic [15:0] adr, input logic [31:0] d);
      for (int i = 0; i < (1 << size); i++) ref_mem[adr + 16'(i)] = 8'(d >> (8 * i));
   endtask

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [15:0] adr);
      logic [31:0] v = 0;
      int n = 1 << size;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[adr + 16'(i)]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (~32'h0 << (8 * n));
      return v;
   endfunction

   // One access: returns response, latency from accept, STB cycles and first SEL/DAT seen
   task automatic access(input logic we, input logic [1:0] size, input logic uns, input logic [15:0] adr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd, output int lat,
                         output int stb, output logic [3:0] sel, output logic [31:0] dat);
      lat = 0; stb = 0; err = 0; rd = 0; sel = 0; dat = 0;
      @(negedge CLK_I);
      chk("req_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns; req_adr = adr; req_wdat = wd;
      @(posedge CLK_I);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge CLK_I);
         if (STB_O) begin
            if (stb == 0) begin sel = SEL_O; dat = DAT_O; end
            stb++;
         end
         if (rsp_valid) begin lat = n; err = rsp_err; rd = rsp_rdat; break; end
      end
      chk("rsp_seen", {31'd0, lat != 0}, 32'd1);
      if (we && !bad(size, adr)) ref_store(size, adr, wd);
   endtask

   logic        e;
   logic [31:0] r, d;
   logic [3:0]  s;
   int          lat, stb;

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
      repeat (2) @(negedge CLK_I);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_bus", {STB_O, WE_O, SEL_O, ADR_O}, 32'd0);
      chk("rst_dat", DAT_O, 32'd0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdat[29:0]}, 32'd0);
      clr = 1'b0;
      RST_N_I = 1'b1;

      access(1, 2'd2, 0, 16'h0010, 32'hDEADBEEF, e, r, lat, stb, s, d);
      chk("sw_sel", s, 4'b1111); chk("sw_lat", lat, 2); chk("sw_err", e, 0);
      access(0, 2'd2, 0, 16'h0010, 0, e, r, lat, stb, s, d);
      chk("lw_dat", r, 32'hDEADBEEF); chk("lw_lat", lat, 3); chk("lw_err", e, 0);

      access(1, 2'd0, 0, 16'h0013, 32'h00000080, e, r, lat, stb, s, d);
      chk("sb_sel", s, 4'b1000); chk("sb_dat", d, 32'h80808080); chk("sb_rdat", r, 0);
      access(0, 2'd0, 0, 16'h0013, 0, e, r, lat, stb, s, d);
      chk("lb_s", r, 32'hFFFFFF80);
      access(0, 2'd0, 1, 16'h0013, 0, e, r, lat, stb, s, d);
      chk("lb_u", r, 32'h00000080);

      access(1, 2'd1, 0, 16'h0022, 32'h00001234, e, r, lat, stb, s, d);
      chk("sh_sel", s, 4'b1100); chk("sh_dat", d, 32'h12341234);
      access(0, 2'd1, 0, 16'h0022, 0, e, r, lat, stb, s, d);
      chk("lh_dat", r, 32'h00001234);

      access(0, 2'd1, 0, 16'h0021, 0, e, r, lat, stb, s, d);
      chk("mis_h_err", e, 1); chk("mis_h_lat", lat, 1); chk("mis_h_stb", stb, 0);
      access(1, 2'd2, 0, 16'h0002, 32'h55, e, r, lat, stb, s, d);
      chk("mis_w_err", e, 1); chk("mis_w_lat", lat, 1); chk("mis_w_stb", stb, 0);
      access(0, 2'd3, 1, 16'h0010, 0, e, r, lat, stb, s, d);
      chk("sz3_err", e, 1); chk("sz3_lat", lat, 1); chk("sz3_stb", stb, 0);

      stall = 1'b1;
      access(0, 2'd2, 0, 16'h0010, 0, e, r, lat, stb, s, d);
      chk("to_stb", stb, TO); chk("to_lat", lat, TO + 1); chk("to_err", e, 1); chk("to_rdat", r, 0);
      stall = 1'b0;
      access(0, 2'd2, 0, 16'h0010, 0, e, r, lat, stb, s, d);
      chk("post_to_dat", r, ref_load(2'd2, 0, 16'h0010)); chk("post_to_err", e, 0);

      stall = 1'b1;
      @(negedge CLK_I);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_adr = 16'h0010;
      @(posedge CLK_I);
      #1 req_valid = 1'b0;
      @(negedge CLK_I);
      chk("mid_stb_pre", {31'd0, STB_O}, 32'd1);
      #3 RST_N_I = 1'b0;
      #1 chk("mid_stb", {31'd0, STB_O}, 32'd0);
      chk("mid_rsp", {31'd0, rsp_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK_I);
         chk("mid_rsp_hold", {31'd0, rsp_valid | STB_O}, 32'd0);
      end
      RST_N_I = 1'b1;
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK_I);
         chk("mid_after", {30'd0, rsp_valid, req_ready}, 32'd1);
      end

      for (int k = 0; k < 300; k++) begin
         logic        we = 1'($urandom);
         logic        uns = 1'($urandom);
         logic [1:0]  sz = 2'($urandom_range(0, 3));
         logic [15:0] a = 16'($urandom_range(16'h0100, 16'h013F));
         logic [31:0] wd = $urandom;
         logic        b = bad(sz, a);
         logic [31:0] ex = (we || b) ? 32'd0 : ref_load(sz, uns, a);
         access(we, sz, uns, a, wd, e, r, lat, stb, s, d);
         chk("rnd_err", e, b);
         chk("rnd_rdat", r, ex);
         chk("rnd_lat", lat, b ? 1 : (we ? 2 : 3));
         chk("rnd_sel", s, b ? 4'd0 : exp_sel(sz, a));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
